// File: rtl/clk_src_pkg.sv
// Shared types and defaults for the dual-source clock mux switch controller.
package clk_src_pkg;

  typedef enum logic [1:0] {
    STABLE   = 2'd0,
    GATE_OFF = 2'd1,
    SWITCH   = 2'd2,
    SETTLE   = 2'd3
  } sw_state_e;

  localparam logic SRC0 = 1'b0;  // single-ended aggregate buffer path
  localparam logic SRC1 = 1'b1;  // differential 125M buffer path

  localparam int NUM_SRC        = 2;
  localparam int DEF_GATE_CYC   = 4;
  localparam int DEF_SETTLE_CYC = 8;
  localparam int DEF_HB_TIMEOUT = 64;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/clk_hb_monitor.sv
// Heartbeat watchdog for one clock source: synchronizes a toggle heartbeat and
// flags the source dead after HB_TIMEOUT cycles without an edge.
module clk_hb_monitor
  import clk_src_pkg::*;
#(
  parameter int HB_TIMEOUT = DEF_HB_TIMEOUT,
  parameter int CNT_W      = $clog2(HB_TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hb,
  output logic alive
);

  localparam logic [CNT_W-1:0] AGE_MAX = CNT_W'(HB_TIMEOUT);
  localparam logic [CNT_W-1:0] AGE_ONE = CNT_W'(1);

  logic [2:0]       sync_q;
  logic             hb_edge;
  logic [CNT_W-1:0] age;

  // [0],[1] form the synchronizer; [2] is the history flop for edge detect.
  assign hb_edge = sync_q[1] ^ sync_q[2];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      age    <= AGE_MAX;
    end else begin
      sync_q <= {sync_q[1:0], hb};
      if (hb_edge)
        age <= '0;
      else if (age < AGE_MAX)
        age <= age + AGE_ONE;
    end
  end

  assign alive = (age < AGE_MAX);

endmodule

// File: rtl/clk_src_switch_ctrl.sv
// Glitch-free switchover sequencer for the dual-source clock mux (gate off, flip sel, settle, gate on).
// Optional build macro CLK_SRC_AUTO_FAILOVER_EN: switch away from a dead active source automatically.
module clk_src_switch_ctrl
  import clk_src_pkg::*;
#(
  parameter int GATE_CYC   = DEF_GATE_CYC,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int HB_TIMEOUT = DEF_HB_TIMEOUT,
  parameter int CNT_W      = $clog2(max3(GATE_CYC, SETTLE_CYC, HB_TIMEOUT) + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_sel,
  input  logic               hb0,
  input  logic               hb1,
  output logic               sel,
  output logic               gate_en,
  output logic               busy,
  output logic               switch_done,
  output logic               req_rej,
  output logic [NUM_SRC-1:0] alive,
  output logic               fault
);

  localparam logic [CNT_W-1:0] GATE_LAST   = CNT_W'(GATE_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  sw_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             boot, rej_done, fo_hold;
  logic             req_mismatch, req_trig, fo_trig, trig, rej_fire, enter_stable;
  logic             sel_nxt, gate_en_nxt, busy_nxt, done_nxt;

  clk_hb_monitor #(
    .HB_TIMEOUT (HB_TIMEOUT),
    .CNT_W      (CNT_W)
  ) u_hb_mon [NUM_SRC-1:0] (
    .clk   (clk),
    .rst_n (rst_n),
    .hb    ({hb1, hb0}),
    .alive (alive)
  );

  assign req_mismatch = (req_sel != sel);
  assign req_trig     = (state == STABLE) && req_mismatch && alive[req_sel];
  assign rej_fire     = (state == STABLE) && req_mismatch && !alive[req_sel]
                        && !rej_done && !fo_hold;
  assign trig         = req_trig || fo_trig;
  assign enter_stable = (state != STABLE) && (state_nxt == STABLE);

  // Suppressed during the post-reset settle so heartbeats have time to show up.
  assign fault = !alive[sel] && !alive[~sel] && !boot;

`ifdef CLK_SRC_AUTO_FAILOVER_EN
  assign fo_trig = (state == STABLE) && !alive[sel] && alive[~sel];

  // After a failover, a stale req_sel pointing at the dead source is not rejected;
  // it stays quiet until software agrees with the new sel or the old source revives.
  always_ff @(posedge clk) begin
    if (!rst_n)
      fo_hold <= 1'b0;
    else if (fo_trig && !req_trig)
      fo_hold <= 1'b1;
    else if ((state == STABLE) && (!req_mismatch || alive[req_sel]))
      fo_hold <= 1'b0;
  end
`else
  assign fo_trig = 1'b0;
  assign fo_hold = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= SETTLE;
      cnt         <= '0;
      sel         <= SRC0;
      gate_en     <= 1'b0;
      busy        <= 1'b1;
      switch_done <= 1'b0;
      req_rej     <= 1'b0;
      boot        <= 1'b1;
      rej_done    <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      sel         <= sel_nxt;
      gate_en     <= gate_en_nxt;
      busy        <= busy_nxt;
      switch_done <= done_nxt;
      req_rej     <= rej_fire;
      if (enter_stable)
        boot <= 1'b0;
      if (!req_mismatch)
        rej_done <= 1'b0;
      else if (rej_fire)
        rej_done <= 1'b1;
    end
  end

  // The SWITCH cycle already has the new sel with the gate closed, so it counts
  // as the first settle cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      STABLE: begin
        if (trig) begin
          state_nxt = GATE_OFF;
          cnt_nxt   = '0;
        end
      end
      GATE_OFF: begin
        if (cnt >= GATE_LAST)
          state_nxt = SWITCH;
        else
          cnt_nxt = cnt + CNT_ONE;
      end
      SWITCH: begin
        state_nxt = (SETTLE_CYC > 1) ? SETTLE : STABLE;
        cnt_nxt   = CNT_ONE;
      end
      SETTLE: begin
        if (cnt >= SETTLE_LAST)
          state_nxt = STABLE;
        else
          cnt_nxt = cnt + CNT_ONE;
      end
      default: begin
        state_nxt = SETTLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered so gate_en never glitches.
  always_comb begin
    gate_en_nxt = (state_nxt == STABLE);
    busy_nxt    = (state_nxt != STABLE);
    sel_nxt     = sel ^ ((state == GATE_OFF) && (state_nxt == SWITCH));
    done_nxt    = enter_stable && !boot;
  end

endmodule

// File: tb/tb_clk_src_switch_ctrl.sv
// Scoreboard bench for clk_src_switch_ctrl: directed switch, reject, failover, fault and reset cases.
module tb_clk_src_switch_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_sel = 1'b0;
  logic       hb0 = 1'b0;
  logic       hb1 = 1'b0;
  logic       hb0_run = 1'b1;
  logic       hb1_run = 1'b1;
  logic       sel, gate_en, busy, switch_done, req_rej, fault;
  logic [1:0] alive;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t0 = 0;
  int s0 = 0;

  typedef struct {
    bit is_rej;
    bit exp_sel;
    int exp_cyc;  // -1: any cycle
  } ev_t;

  ev_t  exp_q[$];
  ev_t  mon_e;
  logic sel_prev = 1'b0;
  logic gate_prev = 1'b0;

  clk_src_switch_ctrl #(
    .GATE_CYC   (4),
    .SETTLE_CYC (8),
    .HB_TIMEOUT (64)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_sel     (req_sel),
    .hb0         (hb0),
    .hb1         (hb1),
    .sel         (sel),
    .gate_en     (gate_en),
    .busy        (busy),
    .switch_done (switch_done),
    .req_rej     (req_rej),
    .alive       (alive),
    .fault       (fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    repeat (10) @(posedge clk);
    #2;
    if (hb0_run) hb0 = ~hb0;
    if (hb1_run) hb1 = ~hb1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every switch_done / req_rej pulse.
  always @(negedge clk) begin
    if (switch_done === 1'b1 || req_rej === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event: switch_done=%0b req_rej=%0b sel=%0b at cycle %0d",
                 switch_done, req_rej, sel, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("event_kind", 32'({switch_done, req_rej}), mon_e.is_rej ? 32'd1 : 32'd2);
        check("event_sel", 32'(sel), 32'(mon_e.exp_sel));
        if (mon_e.exp_cyc >= 0)
          check("event_cycle", cyc, mon_e.exp_cyc);
      end
    end
    if (sel !== sel_prev)
      check("gate_low_on_sel_change", 32'({gate_en, gate_prev}), 32'd0);
    sel_prev  = sel;
    gate_prev = gate_en;
  end

  task automatic wait_neg(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_ev(input bit is_rej, input bit exp_sel, input int exp_cyc);
    ev_t e;
    e.is_rej  = is_rej;
    e.exp_sel = exp_sel;
    e.exp_cyc = exp_cyc;
    exp_q.push_back(e);
  endtask

  // Request sampled on the next edge: sel flips at +5, gate_en/switch_done at +13.
  task automatic request(input logic v, input bit exp_done, input bit exp_rej);
    @(posedge clk);
    #1;
    req_sel = v;
    t0 = cyc;
    if (exp_done) push_ev(1'b0, v, t0 + 13);
    if (exp_rej)  push_ev(1'b1, ~v, t0 + 1);
  endtask

  task automatic boot_check(input string tag);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, "_gate_en"}, 32'(gate_en), 32'(k == 8));
    end
    check({tag, "_sel"}, 32'(sel), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_gate_en", 32'(gate_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_switch_done", 32'(switch_done), 32'd0);
    check("rst_req_rej", 32'(req_rej), 32'd0);
    check("rst_alive", 32'(alive), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    boot_check("boot");
    repeat (30) @(negedge clk);
    check("alive_both", 32'(alive), 32'd3);
    check("fault_none", 32'(fault), 32'd0);

    // Software switch 0 -> 1 with exact latency
    request(1'b1, 1'b1, 1'b0);
    wait_neg(1);
    check("sw1_gate_off", 32'(gate_en), 32'd0);
    check("sw1_busy", 32'(busy), 32'd1);
    wait_neg(3);
    check("sw1_sel_before", 32'(sel), 32'd0);
    wait_neg(1);
    check("sw1_sel_flip", 32'(sel), 32'd1);
    check("sw1_gate_at_flip", 32'(gate_en), 32'd0);
    wait_neg(7);
    check("sw1_gate_still_off", 32'(gate_en), 32'd0);
    wait_neg(1);
    check("sw1_gate_on", 32'(gate_en), 32'd1);
    check("sw1_not_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);

    // Switch back 1 -> 0
    request(1'b0, 1'b1, 1'b0);
    wait_neg(13);
    check("sw0_sel", 32'(sel), 32'd0);
    check("sw0_gate_on", 32'(gate_en), 32'd1);
    repeat (5) @(negedge clk);

    // Request toward a dead source is rejected once
    hb1_run = 1'b0;
    repeat (80) @(negedge clk);
    check("hb1_dead_alive", 32'(alive), 32'd1);
    check("hb1_dead_fault", 32'(fault), 32'd0);
    request(1'b1, 1'b0, 1'b1);
    wait_neg(20);
    check("rej_sel", 32'(sel), 32'd0);
    check("rej_gate_on", 32'(gate_en), 32'd1);
    check("rej_not_busy", 32'(busy), 32'd0);
    request(1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);

    // Active source (src1) dies
    hb1_run = 1'b1;
    repeat (30) @(negedge clk);
    check("hb1_back_alive", 32'(alive), 32'd3);
    request(1'b1, 1'b1, 1'b0);
    wait_neg(13);
    check("sw1b_sel", 32'(sel), 32'd1);
    check("sw1b_gate_on", 32'(gate_en), 32'd1);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 hb1_run = 1'b0;
    s0 = cyc;
`ifdef CLK_SRC_AUTO_FAILOVER_EN
    push_ev(1'b0, 1'b0, -1);
`endif
    repeat (50) @(negedge clk);
    check("hb1_not_yet_dead", 32'(alive), 32'd3);
    check("hb1_not_yet_sel", 32'(sel), 32'd1);
    repeat (60) @(negedge clk);
    check("lost_alive", 32'(alive), 32'd1);
    check("lost_fault", 32'(fault), 32'd0);
    check("lost_gate_on", 32'(gate_en), 32'd1);
`ifdef CLK_SRC_AUTO_FAILOVER_EN
    check("failover_sel", 32'(sel), 32'd0);
    request(1'b0, 1'b0, 1'b0);
`else
    check("no_failover_sel", 32'(sel), 32'd1);
    request(1'b0, 1'b1, 1'b0);
`endif
    wait_neg(16);
    check("back_to_src0_sel", 32'(sel), 32'd0);
    check("back_to_src0_gate", 32'(gate_en), 32'd1);

    // Both sources dead
    hb0_run = 1'b0;
    repeat (80) @(negedge clk);
    check("dead_fault", 32'(fault), 32'd1);
    check("dead_alive", 32'(alive), 32'd0);
    check("dead_gate_on", 32'(gate_en), 32'd1);
    check("dead_not_busy", 32'(busy), 32'd0);
    request(1'b1, 1'b0, 1'b1);
    wait_neg(5);
    check("dead_sel_kept", 32'(sel), 32'd0);
    check("dead_gate_kept", 32'(gate_en), 32'd1);
    request(1'b0, 1'b0, 1'b0);

    // Reset during SETTLE aborts the switch
    hb0_run = 1'b1;
    hb1_run = 1'b1;
    repeat (30) @(negedge clk);
    check("revive_alive", 32'(alive), 32'd3);
    request(1'b1, 1'b0, 1'b0);
    wait_neg(9);
    check("mid_settle_busy", 32'(busy), 32'd1);
    check("mid_settle_sel", 32'(sel), 32'd1);
    @(posedge clk);
    #1;
    rst_n   = 1'b0;
    req_sel = 1'b0;
    wait_neg(1);
    check("abort_sel", 32'(sel), 32'd0);
    check("abort_gate_en", 32'(gate_en), 32'd0);
    check("abort_busy", 32'(busy), 32'd1);
    check("abort_switch_done", 32'(switch_done), 32'd0);
    // Release just after a rising heartbeat so both sources are seen before STABLE.
    wait (hb0 == 1'b0);
    @(posedge hb0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    boot_check("reboot");
    repeat (30) @(negedge clk);
    request(1'b1, 1'b1, 1'b0);
    wait_neg(13);
    check("restart_sel", 32'(sel), 32'd1);
    check("restart_gate_on", 32'(gate_en), 32'd1);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
